nios2_mul_combine: RTL and testbench
====================================

Name: nios2_mul_combine

Overview:
- Downstream stage of the Nios II multiplier cell. Consumes the three registered 16x16 partial products and produces the final 32-bit result for the MUL and MULX* instructions.
  - p1 = src1[15:0]*src2[15:0]
  - p2 = src1[15:0]*src2[31:16]
  - p3 = src1[31:16]*src2[15:0]
- MUL uses a 1-cycle carry-save combine.
- MULXUU/MULXSU/MULXSS compute the missing hi*hi product with an iterative shift-add FSM, then apply signed corrections.
- Valid/ready on both sides; pipeline kill support.

Parameters:
- RADIX_BITS, 1, multiplier bits retired per ITER cycle. Legal values: 1, 2, 4, 8, 16. ITER_CYCLES = 16/RADIX_BITS.

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- reset_n, input, 1, synchronous active-low reset.
- in_valid, input, 1, operands and partial products valid this cycle.
- in_ready, output, 1, block accepts a new operation (high only in IDLE).
- in_op, input, 2, operation: 00 MUL, 01 MULXUU, 10 MULXSU, 11 MULXSS.
- in_src1, input, 32, operand A (signed for SU/SS).
- in_src2, input, 32, operand B (signed for SS only).
- in_p1, in_p2, in_p3, input, 32 each, partial products, aligned with in_valid.
- in_kill, input, 1, flush any in-flight operation.
- out_valid, output, 1, result valid.
- out_ready, input, 1, consumer accepts result.
- out_result, output, 32, MUL low word or MULX high word.
- busy, output, 1, state != IDLE.

Behaviour:
- Reset (reset_n=0 at an edge, any state): state=IDLE, out_valid=0, out_result=0, busy=0, iteration counter=0. Reset overrides kill and accept.
- States: IDLE, ITER, FIX, OUT.
- Accept: in_valid & in_ready & ~in_kill in IDLE.
- IDLE, accept of MUL:
  - out_result <= p1 + ((p2+p3)<<16), truncated to 32 bits.
  - Next state OUT; latency 1 (out_valid in cycle T+1).
- IDLE, accept of MULX*:
  - Latch p1, mid = p2+p3 (33 bits), src1, src2, op; clear acc.
  - Next state ITER, cnt=0.
- ITER:
  - acc += (src1[31:16] * next RADIX_BITS of src2[31:16]) << shift.
  - cnt++. After ITER_CYCLES cycles, acc = p4 = a_hi*b_hi (32 bits) and state goes to FIX.
- FIX (1 cycle):
  - c = (p1[31:16] + mid[15:0]) >> 16.
  - hi_uu = p4 + mid[32:16] + c, mod 2^32.
  - MULXSU: hi = hi_uu - (src1[31] ? src2 : 0).
  - MULXSS: hi = hi_uu - (src1[31] ? src2 : 0) - (src2[31] ? src1 : 0).
  - Register out_result; next state OUT.
- MULX latency: out_valid first high in cycle T+2+ITER_CYCLES (T+18 with RADIX_BITS=1).
- OUT:
  - out_valid=1; out_result held stable while out_ready=0.
  - out_valid & out_ready → IDLE; new accept no earlier than the following cycle (no same-cycle re-accept).
- in_kill:
  - In ITER/FIX/OUT: next state IDLE, out_valid=0, result dropped.
  - In IDLE with in_valid: no accept.
  - Kill has priority over out_ready.
- Inputs other than in_valid/in_kill are ignored outside IDLE. Partial products are sampled only at accept.
- No overflow flags; all arithmetic wraps modulo 2^32.

Decomposition:
- Shared package nios2_mul_pkg:
  - op encoding constants: MUL_OP_MUL, MUL_OP_MULXUU, MUL_OP_MULXSU, MUL_OP_MULXSS.
  - state encoding localparams.
  - function iter_cycles(RADIX_BITS).
- One sub-module, nios2_mul_iter16: 16x16 iterative shift-add with start/done/clear, parameterised by RADIX_BITS.
- Combine, FIX and handshake logic stay in the top.

Test Plan:
- MUL, src1=0x00010003, src2=0x00020005, p1=15, p2=6, p3=5 → out_result=0x000B000F, out_valid at T+1.
- MULXUU, 0xFFFFFFFF × 0xFFFFFFFF (p1=p2=p3=0xFFFE0001) → 0xFFFFFFFE at T+18; repeat with RADIX_BITS=4 → T+6.
- MULXSS, 0xFFFFFFFF × 0x00000002 → 0xFFFFFFFF. MULXSU, 0x80000000 × 0x80000000 → 0xC0000000.
- Backpressure: out_ready=0 for 5 cycles after MUL result → out_valid and out_result stable, in_ready=0; out_ready=1 → IDLE next cycle.
- in_kill at ITER cycle 7 → next cycle IDLE, in_ready=1, no out_valid pulse; a following MUL completes correctly.
- reset_n=0 for one cycle during FIX → next cycle out_valid=0, out_result=0, busy=0, in_ready=1.

Source files
------------

// File: rtl/nios2_mul_pkg.sv
// Shared definitions for the Nios II multiplier combine stage:
// op encodings, FSM state encoding and the iteration-count helper.
package nios2_mul_pkg;

    localparam logic [1:0] MUL_OP_MUL    = 2'b00;
    localparam logic [1:0] MUL_OP_MULXUU = 2'b01;
    localparam logic [1:0] MUL_OP_MULXSU = 2'b10;
    localparam logic [1:0] MUL_OP_MULXSS = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ITER = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_OUT  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_ITER = ST_ITER,
        S_FIX  = ST_FIX,
        S_OUT  = ST_OUT
    } state_e;

    function automatic int iter_cycles(input int radix_bits);
        return 16 / radix_bits;
    endfunction

endpackage

// File: rtl/nios2_mul_combine_if.sv
// Handshake bundle of the multiplier combine stage.
// master: issuing/consuming side; slave: the combine stage itself.
interface nios2_mul_combine_if;

    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_src1;
    logic [31:0] in_src2;
    logic [31:0] in_p1;
    logic [31:0] in_p2;
    logic [31:0] in_p3;
    logic        in_kill;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        busy;

    modport master (
        output in_valid, in_op, in_src1, in_src2,
        output in_p1, in_p2, in_p3, in_kill, out_ready,
        input  in_ready, out_valid, out_result, busy
    );

    modport slave (
        input  in_valid, in_op, in_src1, in_src2,
        input  in_p1, in_p2, in_p3, in_kill, out_ready,
        output in_ready, out_valid, out_result, busy
    );

endinterface

// File: rtl/nios2_mul_iter16.sv
// Iterative 16x16 unsigned shift-add multiplier, RADIX_BITS per cycle.
// Ports: clk, reset_n, start_i (load+clear), clear_i (abort), a_i, b_i,
// done_o (last step this cycle), acc_o (product valid the cycle after done_o).
module nios2_mul_iter16
    import nios2_mul_pkg::*;
#(
    parameter int RADIX_BITS = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start_i,
    input  logic        clear_i,
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic        done_o,
    output logic [31:0] acc_o
);

    localparam int         ITER = iter_cycles(RADIX_BITS);
    localparam logic [4:0] LAST = 5'(ITER - 1);

    logic        run_q;
    logic [4:0]  cnt_q;
    logic [31:0] acc_q;
    logic [31:0] a_q;
    logic [15:0] b_q;
    logic [31:0] step_d;

    // a_q is pre-shifted and b_q consumed from the bottom, so the
    // per-cycle term needs no variable shifter.
    assign step_d = a_q * {{(32 - RADIX_BITS){1'b0}}, b_q[RADIX_BITS-1:0]};
    assign done_o = run_q && (cnt_q == LAST);
    assign acc_o  = acc_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            run_q <= 1'b0;
            cnt_q <= '0;
            acc_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
        end else if (clear_i) begin
            run_q <= 1'b0;
            cnt_q <= '0;
        end else if (start_i) begin
            run_q <= 1'b1;
            cnt_q <= '0;
            acc_q <= '0;
            a_q   <= {16'h0000, a_i};
            b_q   <= b_i;
        end else if (run_q) begin
            acc_q <= acc_q + step_d;
            a_q   <= a_q << RADIX_BITS;
            b_q   <= b_q >> RADIX_BITS;
            if (cnt_q == LAST) begin
                run_q <= 1'b0;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 5'd1;
            end
        end
    end

endmodule

// File: rtl/nios2_mul_combine.sv
// Final stage of the Nios II multiplier: MUL low word from partial
// products, MULX* high word via iterative hi*hi plus signed fixup.
// Ports: clk, reset_n (sync, active low), bus (slave handshake bundle).
module nios2_mul_combine
    import nios2_mul_pkg::*;
#(
    parameter int RADIX_BITS = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    nios2_mul_combine_if.slave   bus
);

    state_e      state_q, state_d;
    logic        out_valid_q;
    logic        busy_q;
    logic [31:0] res_q;
    logic [15:0] p1_hi_q;
    logic [32:0] mid_q;
    logic [31:0] src1_q;
    logic [31:0] src2_q;
    logic [1:0]  op_q;

    logic        accept;
    logic        is_mul;
    logic        iter_done;
    logic [31:0] p4;
    logic [31:0] mul_res_d;
    logic [32:0] mid_d;
    logic [16:0] lo_sum;
    logic [31:0] hi_uu;
    logic [31:0] corr_a;
    logic [31:0] corr_b;
    logic [31:0] fix_res_d;

    assign accept = bus.in_valid & ~busy_q & ~bus.in_kill;
    assign is_mul = (bus.in_op == MUL_OP_MUL);

    assign mul_res_d = bus.in_p1 + ((bus.in_p2 + bus.in_p3) << 16);
    assign mid_d     = {1'b0, bus.in_p2} + {1'b0, bus.in_p3};

    // Carry out of bit 31 of the low word feeds the high word.
    assign lo_sum = {1'b0, p1_hi_q} + {1'b0, mid_q[15:0]};
    assign hi_uu  = p4 + {15'h0000, mid_q[32:16]} + {31'h0, lo_sum[16]};

    // Signed high word = unsigned high word minus the sign-weighted
    // opposite operand for each operand treated as signed.
    assign corr_a = ((op_q != MUL_OP_MULXUU) && src1_q[31]) ? src2_q : '0;
    assign corr_b = ((op_q == MUL_OP_MULXSS) && src2_q[31]) ? src1_q : '0;
    assign fix_res_d = hi_uu - corr_a - corr_b;

    nios2_mul_iter16 #(
        .RADIX_BITS(RADIX_BITS)
    ) u_iter (
        .clk    (clk),
        .reset_n(reset_n),
        .start_i(accept & ~is_mul),
        .clear_i(bus.in_kill),
        .a_i    (bus.in_src1[31:16]),
        .b_i    (bus.in_src2[31:16]),
        .done_o (iter_done),
        .acc_o  (p4)
    );

    always_comb begin
        state_d = state_q;
        if (bus.in_kill) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: if (bus.in_valid) state_d = is_mul ? S_OUT : S_ITER;
                S_ITER: if (iter_done) state_d = S_FIX;
                S_FIX:  state_d = S_OUT;
                S_OUT:  if (bus.out_ready) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            res_q       <= '0;
            p1_hi_q     <= '0;
            mid_q       <= '0;
            src1_q      <= '0;
            src2_q      <= '0;
            op_q        <= MUL_OP_MUL;
        end else begin
            state_q     <= state_d;
            out_valid_q <= (state_d == S_OUT);
            busy_q      <= (state_d != S_IDLE);
            if (accept) begin
                p1_hi_q <= bus.in_p1[31:16];
                mid_q   <= mid_d;
                src1_q  <= bus.in_src1;
                src2_q  <= bus.in_src2;
                op_q    <= bus.in_op;
                if (is_mul) res_q <= mul_res_d;
            end
            if (state_q == S_FIX && !bus.in_kill) res_q <= fix_res_d;
        end
    end

    assign bus.in_ready   = ~busy_q;
    assign bus.busy       = busy_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = res_q;

endmodule

// File: tb/tb_nios2_mul_combine.sv
// Self-checking bench for nios2_mul_combine: two instances (radix 1 and 4)
// share stimulus; a scoreboard checks result and first-valid cycle.
module tb_nios2_mul_combine;
    import nios2_mul_pkg::*;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        int          due;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_kill;
    logic        out_ready;
    logic [1:0]  in_op;
    logic [31:0] s1, s2, p1, p2, p3;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_bad = 0;
    exp_t q1[$];
    exp_t q4[$];
    exp_t e1, e4;
    bit   seen1 = 0;
    bit   seen4 = 0;

    nios2_mul_combine_if b1();
    nios2_mul_combine_if b4();

    assign b1.in_valid = in_valid;
    assign b1.in_kill = in_kill;
    assign b1.out_ready = out_ready;
    assign b1.in_op = in_op;
    assign b1.in_src1 = s1;
    assign b1.in_src2 = s2;
    assign b1.in_p1 = p1;
    assign b1.in_p2 = p2;
    assign b1.in_p3 = p3;
    assign b4.in_valid = in_valid;
    assign b4.in_kill = in_kill;
    assign b4.out_ready = out_ready;
    assign b4.in_op = in_op;
    assign b4.in_src1 = s1;
    assign b4.in_src2 = s2;
    assign b4.in_p1 = p1;
    assign b4.in_p2 = p2;
    assign b4.in_p3 = p3;

    nios2_mul_combine #(.RADIX_BITS(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(b1.slave)
    );
    nios2_mul_combine #(.RADIX_BITS(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .bus(b4.slave)
    );

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] ae, be, pr;
        ae = (op == MUL_OP_MULXSU || op == MUL_OP_MULXSS) ?
             {{32{a[31]}}, a} : {32'h0, a};
        be = (op == MUL_OP_MULXSS) ? {{32{b[31]}}, b} : {32'h0, b};
        pr = ae * be;
        return (op == MUL_OP_MUL) ? pr[31:0] : pr[63:32];
    endfunction

    // Scoreboard: compare on the first cycle each out_valid rises.
    always @(negedge clk) begin
        if (reset_n) begin
            if (b1.out_valid && !seen1) begin
                if (q1.size() == 0) begin
                    check("r1_unexpected_valid", 32'(b1.out_valid), 32'd0);
                end else begin
                    e1 = q1.pop_front();
                    check("r1_result", b1.out_result, e1.res);
                    check("r1_latency", 32'(cyc), 32'(e1.due));
                end
            end
            if (b4.out_valid && !seen4) begin
                if (q4.size() == 0) begin
                    check("r4_unexpected_valid", 32'(b4.out_valid), 32'd0);
                end else begin
                    e4 = q4.pop_front();
                    check("r4_result", b4.out_result, e4.res);
                    check("r4_latency", 32'(cyc), 32'(e4.due));
                end
            end
        end
        seen1 = b1.out_valid;
        seen4 = b4.out_valid;
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp,
                         input bit push1, input bit push4);
        int n = 0;
        while (!(b1.in_ready && b4.in_ready) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("issue_ready_timeout", 32'(n >= 200), 32'd0);
        in_valid = 1;
        in_op = op;
        s1 = a;
        s2 = b;
        p1 = {16'h0, a[15:0]} * {16'h0, b[15:0]};
        p2 = {16'h0, a[15:0]} * {16'h0, b[31:16]};
        p3 = {16'h0, a[31:16]} * {16'h0, b[15:0]};
        if (push1) q1.push_back('{exp, cyc + ((op == MUL_OP_MUL) ? 1 : 18)});
        if (push4) q4.push_back('{exp, cyc + ((op == MUL_OP_MUL) ? 1 : 6)});
        @(posedge clk); #1;
        in_valid = 0;
        // Junk on the data inputs must be ignored once accepted.
        in_op = 2'($urandom);
        s1 = $urandom;
        s2 = $urandom;
        p1 = $urandom;
        p2 = $urandom;
        p3 = $urandom;
    endtask

    task automatic drain();
        int n = 0;
        while ((q1.size() != 0 || q4.size() != 0 ||
                !b1.in_ready || !b4.in_ready) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_timeout", 32'(n >= 100), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[8];
        vt[0] = '{MUL_OP_MUL,    32'h00010003, 32'h00020005, 32'h000B000F};
        vt[1] = '{MUL_OP_MULXUU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
        vt[2] = '{MUL_OP_MULXSS, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF};
        vt[3] = '{MUL_OP_MULXSU, 32'h80000000, 32'h80000000, 32'hC0000000};
        for (int i = 4; i < 8; i++) begin
            vt[i].op = 2'(i - 4);
            vt[i].a = $urandom;
            vt[i].b = $urandom;
            vt[i].exp = model(vt[i].op, vt[i].a, vt[i].b);
        end

        reset_n = 0;
        in_valid = 0;
        in_kill = 0;
        out_ready = 1;
        in_op = 0;
        s1 = 0; s2 = 0; p1 = 0; p2 = 0; p3 = 0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1;

        check("rst_out_valid", 32'(b1.out_valid), 32'd0);
        check("rst_out_result", b1.out_result, 32'd0);
        check("rst_busy", 32'(b1.busy), 32'd0);
        check("rst_in_ready", 32'(b1.in_ready), 32'd1);
        check("rst4_in_ready", 32'(b4.in_ready), 32'd1);

        for (int i = 0; i < 8; i++) begin
            issue(vt[i].op, vt[i].a, vt[i].b, vt[i].exp, 1, 1);
            drain();
        end

        // Backpressure on a MUL result.
        out_ready = 0;
        issue(MUL_OP_MUL, 32'h00010003, 32'h00020005, 32'h000B000F, 1, 1);
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", 32'(b1.out_valid), 32'd1);
            check("bp_out_result", b1.out_result, 32'h000B000F);
            check("bp_in_ready", 32'(b1.in_ready), 32'd0);
            check("bp4_out_valid", 32'(b4.out_valid), 32'd1);
            @(posedge clk); #1;
        end
        out_ready = 1;
        @(posedge clk); #1;
        check("bp_release_valid", 32'(b1.out_valid), 32'd0);
        check("bp_release_ready", 32'(b1.in_ready), 32'd1);
        drain();

        // Kill with in_valid in IDLE: nothing accepted.
        in_valid = 1;
        in_kill = 1;
        in_op = MUL_OP_MUL;
        @(posedge clk); #1;
        in_valid = 0;
        in_kill = 0;
        check("idle_kill_busy", 32'(b1.busy), 32'd0);
        check("idle_kill_valid", 32'(b1.out_valid), 32'd0);

        // Kill at ITER cycle 7 of the radix-1 instance.
        issue(MUL_OP_MULXUU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, 1);
        repeat (6) begin
            @(posedge clk); #1;
        end
        check("kill_busy_before", 32'(b1.busy), 32'd1);
        in_kill = 1;
        @(posedge clk); #1;
        in_kill = 0;
        check("kill_in_ready", 32'(b1.in_ready), 32'd1);
        check("kill_busy", 32'(b1.busy), 32'd0);
        check("kill_out_valid", 32'(b1.out_valid), 32'd0);
        issue(MUL_OP_MUL, 32'h00010003, 32'h00020005, 32'h000B000F, 1, 1);
        drain();

        // Reset while the radix-1 instance sits in FIX.
        issue(MUL_OP_MULXSS, 32'h12345678, 32'h87654321,
              model(MUL_OP_MULXSS, 32'h12345678, 32'h87654321), 0, 1);
        repeat (16) begin
            @(posedge clk); #1;
        end
        check("fix_busy", 32'(b1.busy), 32'd1);
        reset_n = 0;
        @(posedge clk); #1;
        reset_n = 1;
        check("rfix_out_valid", 32'(b1.out_valid), 32'd0);
        check("rfix_out_result", b1.out_result, 32'd0);
        check("rfix_busy", 32'(b1.busy), 32'd0);
        check("rfix_in_ready", 32'(b1.in_ready), 32'd1);
        check("rfix4_out_result", b4.out_result, 32'd0);
        check("rfix_queue4", 32'(q4.size()), 32'd0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("rfix_quiet", 32'(b1.out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
